// File: rtl/axis_averager_if.sv
// Stream bundle for axis_averager: the sample input stream (s_axis_*) and
// the averaged result stream (m_axis_*).
//   slave  : view taken by the averager (consumes s_axis_*, produces m_axis_*)
//   master : view taken by the environment driving and draining the averager
interface axis_averager_if #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32
) ();
    logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
    logic                        s_axis_tvalid;
    logic                        s_axis_tready;
    logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_averager.sv
// Block averager: sums 2^L signed samples and emits their floor average.
//   aclk        : clock, rising edge
//   aresetn     : asynchronous active-low reset
//   avg_log2    : requested log2 block length, clamped to MAX_LOG2, latched per block
//   block_count : number of results accepted downstream (wraps)
//   axis        : s_axis_* sample input, m_axis_* result output
module axis_averager #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned MAX_LOG2         = 10
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [3:0]          avg_log2,
    output logic [31:0]         block_count,
    axis_averager_if.slave      axis
);
    localparam int unsigned AccW = AXIS_TDATA_WIDTH + MAX_LOG2;
    localparam int unsigned CntW = MAX_LOG2 + 1;

    logic signed [AccW-1:0]             acc_q, acc_d;
    logic [CntW-1:0]                    cnt_q, cnt_d;
    logic [3:0]                         len_q, len_d;
    logic [AXIS_TDATA_WIDTH-1:0]        data_q, data_d;
    logic                               valid_q, valid_d;
    logic [31:0]                        bc_q, bc_d;

    logic [3:0]                         len_req;
    logic [3:0]                         len_eff;
    logic [CntW-1:0]                    cnt_last;
    logic                               is_last;
    logic                               s_ready;
    logic                               in_xfer;
    logic                               out_xfer;
    logic signed [AXIS_TDATA_WIDTH-1:0] sample_s;
    logic signed [AccW-1:0]             sum;

    always_comb begin
        len_req  = (32'(avg_log2) > MAX_LOG2) ? 4'(MAX_LOG2) : avg_log2;
        // Between blocks the live request decides; mid-block the latched length rules.
        len_eff  = (cnt_q == '0) ? len_req : len_q;
        cnt_last = (CntW'(1) << len_eff) - CntW'(1);
        is_last  = (cnt_q == cnt_last);
        // Only the final sample can be stalled: it would overwrite an unread result.
        s_ready  = !(is_last && valid_q && !axis.m_axis_tready);
        in_xfer  = axis.s_axis_tvalid && s_ready;
        out_xfer = valid_q && axis.m_axis_tready;
        sample_s = axis.s_axis_tdata;
        sum      = acc_q + AccW'(sample_s);
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        data_d  = data_q;
        valid_d = valid_q;
        bc_d    = bc_q;
        if (out_xfer) begin
            valid_d = 1'b0;
            bc_d    = bc_q + 32'd1;
        end
        if (in_xfer) begin
            if (is_last) begin
                acc_d   = '0;
                cnt_d   = '0;
                data_d  = AXIS_TDATA_WIDTH'(sum >>> len_eff);
                valid_d = 1'b1;  // a completion wins over a same-cycle drain
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == '0) begin
                    len_d = len_req;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            bc_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            bc_q    <= bc_d;
        end
    end

    assign axis.s_axis_tready = s_ready;
    assign axis.m_axis_tdata  = data_q;
    assign axis.m_axis_tvalid = valid_q;
    assign block_count        = bc_q;
endmodule

// File: doc/axis_averager.md
AXIS_AVERAGER -- requirements
Module: axis_averager

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, meaning the signed sample width on both the input and output streams.
REQ-002 SHALL have parameter MAX_LOG2, default 10, meaning the largest supported log2 averaging length.
REQ-003 SHALL have port aclk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port avg_log2, input, 4 bits: requested averaging length N = 2^avg_log2.
REQ-006 SHALL have port s_axis_tdata, input, AXIS_TDATA_WIDTH bits: signed input sample.
REQ-007 SHALL have port s_axis_tvalid, input, 1 bit: input sample valid.
REQ-008 SHALL have port s_axis_tready, output, 1 bit: block accepts an input sample.
REQ-009 SHALL have port m_axis_tdata, output, AXIS_TDATA_WIDTH bits: signed averaged result.
REQ-010 SHALL have port m_axis_tvalid, output, 1 bit: result valid.
REQ-011 SHALL have port m_axis_tready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port block_count, output, 32 bits: number of results accepted downstream; wraps modulo 2^32.

Function
REQ-013 SHALL define an input transfer as s_axis_tvalid && s_axis_tready, and an output transfer as m_axis_tvalid && m_axis_tready, both sampled at the rising edge of aclk.
REQ-014 SHALL latch the effective length L = min(avg_log2, MAX_LOG2) only on the first input transfer of each block; avg_log2 changes mid-block SHALL NOT affect that block.
REQ-015 SHALL use a signed accumulator of AXIS_TDATA_WIDTH+MAX_LOG2 bits, sign-extending each sample, so that overflow is impossible.
REQ-016 SHALL have a sample counter that starts at 0 for each block, increments on each input transfer, and completes the block on the transfer where count == 2^L-1.
REQ-017 SHALL, on block completion, load the output register with (accumulator + final sample) arithmetically shifted right by L (floor rounding, truncated to AXIS_TDATA_WIDTH bits), set m_axis_tvalid on the next cycle, and clear the accumulator and counter.
REQ-018 SHALL pass each sample through unchanged (L = 0) when avg_log2 = 0, with one result per input transfer.
REQ-019 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 SHALL clear m_axis_tvalid after an output transfer unless a new result loads in the same cycle; a simultaneous output transfer and block completion SHALL leave m_axis_tvalid=1 holding the new result.
REQ-021 SHALL drive s_axis_tready = !(count == 2^L-1 && m_axis_tvalid && !m_axis_tready), computed combinationally, so that a result is never overwritten and no sample is dropped; non-final samples SHALL always be accepted.
REQ-022 SHALL, when avg_log2 = 0 and no block is in progress, use L = 0 for the s_axis_tready decision.
REQ-023 SHALL increment block_count by 1 on each output transfer.
REQ-024 SHALL exhibit a latency of exactly 1 cycle from the final input transfer of a block to m_axis_tvalid=1 when the output register is free.
REQ-025 SHALL sustain 1 sample per cycle on input when m_axis_tready is held high.

Reset
REQ-026 SHALL, while aresetn=0, asynchronously force the accumulator, counter, m_axis_tdata, m_axis_tvalid and block_count to 0.
REQ-027 SHALL drive s_axis_tready=1 while aresetn=0 only as the combinational result of REQ-021 with the reset state; no transfer SHALL be registered during reset.
REQ-028 SHALL discard a partially accumulated block and any pending result when reset is asserted mid-operation; after release, the next input transfer SHALL start a new block.

Verification
REQ-029 SHALL verify: avg_log2=2, samples 4,8,12,16 back-to-back, m_axis_tready=1 -> m_axis_tdata=10 one cycle after the 4th sample; block_count=1.
REQ-030 SHALL verify: avg_log2=1, samples -3,-4 -> result -4 (floor of -3.5).
REQ-031 SHALL verify: avg_log2=0, m_axis_tready=0, samples 5 then 6 -> 5 is held; s_axis_tready=0 while 6 is presented; raising m_axis_tready delivers 5 then 6 with no loss.
REQ-032 SHALL verify: avg_log2=2 with avg_log2 changed to 0 after the 1st sample -> the block still completes after 4 samples; the following block uses N=1.
REQ-033 SHALL verify: avg_log2=3, 0x7FFFFFFF x8 -> result 0x7FFFFFFF (no overflow); avg_log2=15 with MAX_LOG2=10 -> block of 1024 samples.
REQ-034 SHALL verify: aresetn pulsed low after 2 of 4 samples -> all outputs are 0; the next 4 samples 1,1,1,1 -> result 1.
